// File: rtl/y_entry_filter_if.sv
// Bus bundle for y_entry_filter: change-record input, yMem read port and calc_y result port.
interface y_entry_filter_if #(
    parameter int SLOTS  = 4,
    parameter int IDX_W  = 16,
    parameter int VAL_W  = 48,
    parameter int ADDR_W = 16
);
    // valid/ready: a transfer happens on a rising edge where both are high; the source
    // holds valid and its payload stable until then. mem_req/mem_rvalid are one-cycle strobes.
    logic                             chg_valid;
    logic                             chg_ready;
    logic [IDX_W-1:0]                 chg_row;
    logic [IDX_W-1:0]                 chg_col;
    logic [VAL_W-1:0]                 chg_delta;
    logic                             mem_req;
    logic [ADDR_W-1:0]                mem_addr;
    logic                             mem_rvalid;
    logic [SLOTS*(IDX_W+VAL_W)-1:0]   mem_rdata;
    logic                             out_valid;
    logic                             out_ready;
    logic [IDX_W-1:0]                 out_row;
    logic [VAL_W-1:0]                 out_diag;
    logic [VAL_W-1:0]                 out_offdiag;
    logic [VAL_W-1:0]                 out_delta;
    logic [1:0]                       out_found;
    logic                             out_done;

    modport slave (
        input  chg_valid, chg_row, chg_col, chg_delta, mem_rvalid, mem_rdata, out_ready,
        output chg_ready, mem_req, mem_addr, out_valid, out_row, out_diag, out_offdiag,
               out_delta, out_found, out_done
    );

    modport master (
        output chg_valid, chg_row, chg_col, chg_delta, mem_rvalid, mem_rdata, out_ready,
        input  chg_ready, mem_req, mem_addr, out_valid, out_row, out_diag, out_offdiag,
               out_delta, out_found, out_done
    );
endinterface

// File: rtl/y_entry_filter.sv
// Y-row entry filter: fetches Y(i,i)/Y(i,j), then Y(j,j)/Y(j,i), for one admittance change.
// Optional YFILT_MISS_CNT_EN adds an 8-bit saturating count of incomplete result sets.
module y_entry_filter #(
    parameter int SLOTS         = 4,
    parameter int IDX_W         = 16,
    parameter int VAL_W         = 48,
    parameter int WORDS_PER_ROW = 2,
    parameter int ADDR_W        = 16
) (
    input  logic              clock,
    input  logic              reset,
    y_entry_filter_if.slave   bus,
    output logic [2:0]        dbg_state
`ifdef YFILT_MISS_CNT_EN
    ,
    output logic [7:0]        miss_cnt
`endif
);
    localparam int SLOT_W = IDX_W + VAL_W;
    localparam int WORD_W = (WORDS_PER_ROW > 1) ? $clog2(WORDS_PER_ROW) : 1;
    localparam logic [IDX_W-1:0] EMPTY_COL = '1;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_REQ  = 3'd1,
        S_WAIT = 3'd2,
        S_SCAN = 3'd3,
        S_EMIT = 3'd4
    } state_t;

    state_t                     state_q, state_d;
    logic [IDX_W-1:0]           row_q, other_q;
    logic [VAL_W-1:0]           delta_q, diag_q, off_q;
    logic                       dfound_q, ofound_q, pass_q;
    logic [WORD_W-1:0]          word_q;
    logic [SLOTS*SLOT_W-1:0]    rdata_q;

    logic                       scan_dfound, scan_ofound, scan_empty, scan_done;
    logic [VAL_W-1:0]           scan_diag, scan_off;
    logic                       single, last_word;

    assign single    = (row_q == other_q);
    assign last_word = (word_q == WORD_W'(WORDS_PER_ROW - 1));
    assign scan_done = (scan_dfound && scan_ofound) || scan_empty || last_word;

    // Slots are walked lowest first so the first hit of a column wins; an empty slot
    // masks everything after it.
    always_comb begin
        scan_dfound = dfound_q;
        scan_ofound = ofound_q;
        scan_diag   = diag_q;
        scan_off    = off_q;
        scan_empty  = 1'b0;
        for (int k = 0; k < SLOTS; k++) begin
            if (!scan_empty) begin
                if (rdata_q[(k+1)*SLOT_W-1 -: IDX_W] == EMPTY_COL) begin
                    scan_empty = 1'b1;
                end else begin
                    if (rdata_q[(k+1)*SLOT_W-1 -: IDX_W] == row_q && !scan_dfound) begin
                        scan_dfound = 1'b1;
                        scan_diag   = rdata_q[k*SLOT_W +: VAL_W];
                    end
                    if (rdata_q[(k+1)*SLOT_W-1 -: IDX_W] == other_q && !scan_ofound) begin
                        scan_ofound = 1'b1;
                        scan_off    = rdata_q[k*SLOT_W +: VAL_W];
                    end
                end
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (bus.chg_valid) state_d = S_REQ;
            S_REQ:  state_d = S_WAIT;
            S_WAIT: if (bus.mem_rvalid) state_d = S_SCAN;
            S_SCAN: state_d = scan_done ? S_EMIT : S_REQ;
            S_EMIT: if (bus.out_ready) state_d = (pass_q || single) ? S_IDLE : S_REQ;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            row_q    <= '0;
            other_q  <= '0;
            delta_q  <= '0;
            diag_q   <= '0;
            off_q    <= '0;
            dfound_q <= 1'b0;
            ofound_q <= 1'b0;
            pass_q   <= 1'b0;
            word_q   <= '0;
            rdata_q  <= '0;
        end else begin
            case (state_q)
                S_IDLE: if (bus.chg_valid) begin
                    row_q    <= bus.chg_row;
                    other_q  <= bus.chg_col;
                    delta_q  <= bus.chg_delta;
                    pass_q   <= 1'b0;
                    word_q   <= '0;
                    dfound_q <= 1'b0;
                    ofound_q <= 1'b0;
                    diag_q   <= '0;
                    off_q    <= '0;
                end
                S_WAIT: if (bus.mem_rvalid) rdata_q <= bus.mem_rdata;
                S_SCAN: begin
                    dfound_q <= scan_dfound;
                    ofound_q <= scan_ofound;
                    diag_q   <= scan_diag;
                    off_q    <= scan_off;
                    if (!scan_done) word_q <= word_q + WORD_W'(1);
                end
                // Second pass scans row j with the roles of row and other exchanged.
                S_EMIT: if (bus.out_ready && !pass_q && !single) begin
                    row_q    <= other_q;
                    other_q  <= row_q;
                    dfound_q <= 1'b0;
                    ofound_q <= 1'b0;
                    diag_q   <= '0;
                    off_q    <= '0;
                    word_q   <= '0;
                    pass_q   <= 1'b1;
                end
                default: ;
            endcase
        end
    end

`ifdef YFILT_MISS_CNT_EN
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            miss_cnt <= '0;
        end else if (state_q == S_EMIT && bus.out_ready && !(dfound_q && ofound_q)
                     && miss_cnt != 8'hFF) begin
            miss_cnt <= miss_cnt + 8'd1;
        end
    end
`endif

    assign bus.chg_ready   = (state_q == S_IDLE);
    assign bus.mem_req     = (state_q == S_REQ);
    assign bus.mem_addr    = (state_q == S_REQ)
                           ? ADDR_W'(row_q) * ADDR_W'(WORDS_PER_ROW) + ADDR_W'(word_q)
                           : '0;
    assign bus.out_valid   = (state_q == S_EMIT);
    assign bus.out_done    = (state_q == S_EMIT) && (pass_q || single);
    assign bus.out_row     = row_q;
    assign bus.out_diag    = diag_q;
    assign bus.out_offdiag = off_q;
    assign bus.out_delta   = delta_q;
    assign bus.out_found   = {dfound_q, ofound_q};
    assign dbg_state       = state_q;
endmodule

// File: tb/tb_y_entry_filter.sv
// Self-checking bench for y_entry_filter: directed scenarios plus randomized records vs a row model.
module tb_y_entry_filter;
  localparam int SLOTS = 4;
  localparam int IDX_W = 16;
  localparam int VAL_W = 48;
  localparam int WPR = 2;
  localparam int ADDR_W = 16;
  localparam int SLOT_W = IDX_W + VAL_W;
  localparam int WORD_BITS = SLOTS * SLOT_W;
  localparam int EXP_W = IDX_W + 3 * VAL_W + 3;
  localparam int RST_W = 1 + 1 + ADDR_W + 1 + 1 + 2 + IDX_W + 3 * VAL_W + 3;
  localparam logic [IDX_W-1:0] EMPTY = '1;

  logic clock = 1'b0;
  logic reset = 1'b0;
  logic [2:0] dbg_state;
`ifdef YFILT_MISS_CNT_EN
  logic [7:0] miss_cnt;
  int exp_miss = 0;
`endif

  always #5 clock = ~clock;

  y_entry_filter_if #(.SLOTS(SLOTS), .IDX_W(IDX_W), .VAL_W(VAL_W), .ADDR_W(ADDR_W)) bus ();

  y_entry_filter #(
    .SLOTS(SLOTS), .IDX_W(IDX_W), .VAL_W(VAL_W), .WORDS_PER_ROW(WPR), .ADDR_W(ADDR_W)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus(bus),
    .dbg_state(dbg_state)
`ifdef YFILT_MISS_CNT_EN
    ,
    .miss_cnt(miss_cnt)
`endif
  );

  int errors = 0;
  int checks = 0;
  logic [EXP_W-1:0] exp_q[$];
  logic [ADDR_W-1:0] exp_addr_q[$];
  logic [ADDR_W-1:0] req_log[$];
  logic [WORD_BITS-1:0] mem_words[int];
  int mem_lat_max = 1;

  // ---------------- memory model ----------------
  function automatic logic [WORD_BITS-1:0] read_word(input logic [ADDR_W-1:0] a);
    if (mem_words.exists(int'(a))) return mem_words[int'(a)];
    return '1;
  endfunction

  task automatic set_slot(input int addr, input int k, input logic [IDX_W-1:0] col,
                          input logic [VAL_W-1:0] val);
    logic [WORD_BITS-1:0] w;
    w = read_word(ADDR_W'(addr));
    w[(k+1)*SLOT_W-1 -: SLOT_W] = {col, val};
    mem_words[addr] = w;
  endtask

  logic pend = 1'b0;
  int pend_cnt = 0;
  logic [ADDR_W-1:0] pend_addr = '0;

  initial begin
    bus.mem_rvalid = 1'b0;
    bus.mem_rdata = '0;
    forever begin
      @(negedge clock);
      bus.mem_rvalid = 1'b0;
      if (!reset) begin
        pend = 1'b0;
      end else begin
        if (pend) begin
          if (pend_cnt == 0) begin
            bus.mem_rvalid = 1'b1;
            bus.mem_rdata = read_word(pend_addr);
            pend = 1'b0;
          end else begin
            pend_cnt--;
          end
        end
        if (bus.mem_req === 1'b1) begin
          req_log.push_back(bus.mem_addr);
          pend = 1'b1;
          pend_addr = bus.mem_addr;
          pend_cnt = $urandom_range(1, mem_lat_max) - 1;
        end
      end
    end
  end

  // ---------------- reference model ----------------
  // The row is treated as one flat slot list; the scan stops at the first empty slot or
  // at the end of the word where both columns have been seen.
  task automatic model_row(input logic [IDX_W-1:0] r, input logic [IDX_W-1:0] o,
                           output logic [VAL_W-1:0] dv, output logic [VAL_W-1:0] ov,
                           output logic [1:0] f, output int nwords);
    int e, pd, po, stop, last;
    logic [WORD_BITS-1:0] w;
    logic [IDX_W-1:0] col;
    logic [VAL_W-1:0] val;
    e = -1; pd = -1; po = -1;
    dv = '0; ov = '0;
    for (int p = 0; p < WPR * SLOTS; p++) begin
      w = read_word(ADDR_W'(int'(r) * WPR + p / SLOTS));
      col = w[((p % SLOTS) + 1) * SLOT_W - 1 -: IDX_W];
      val = w[(p % SLOTS) * SLOT_W +: VAL_W];
      if (e < 0) begin
        if (col == EMPTY) e = p;
        else begin
          if (col == r && pd < 0) begin pd = p; dv = val; end
          if (col == o && po < 0) begin po = p; ov = val; end
        end
      end
    end
    stop = WPR * SLOTS - 1;
    if (e >= 0) stop = e;
    if (pd >= 0 && po >= 0) begin
      last = (pd > po) ? pd : po;
      if (last < stop) stop = last;
    end
    nwords = stop / SLOTS + 1;
    f = {pd >= 0, po >= 0};
  endtask

  task automatic expect_record(input logic [IDX_W-1:0] i, input logic [IDX_W-1:0] j,
                               input logic [VAL_W-1:0] d);
    logic [VAL_W-1:0] dv, ov;
    logic [1:0] f;
    int nw;
    model_row(i, j, dv, ov, f, nw);
    exp_q.push_back({i, dv, ov, d, f, (i == j)});
    for (int w = 0; w < nw; w++) exp_addr_q.push_back(ADDR_W'(int'(i) * WPR + w));
    if (i != j) begin
      model_row(j, i, dv, ov, f, nw);
      exp_q.push_back({j, dv, ov, d, f, 1'b1});
      for (int w = 0; w < nw; w++) exp_addr_q.push_back(ADDR_W'(int'(j) * WPR + w));
    end
  endtask

  // ---------------- drivers ----------------
  task automatic send_record(input logic [IDX_W-1:0] i, input logic [IDX_W-1:0] j,
                             input logic [VAL_W-1:0] d);
    int n;
    n = 0;
    while (bus.chg_ready !== 1'b1 && n < 300) begin @(negedge clock); n++; end
    if (bus.chg_ready !== 1'b1) begin
      checks++; errors++;
      $display("FAIL chg_ready_timeout: chg_ready=%b required 1", bus.chg_ready);
    end
    bus.chg_valid = 1'b1;
    bus.chg_row = i;
    bus.chg_col = j;
    bus.chg_delta = d;
    @(negedge clock);
    bus.chg_valid = 1'b0;
  endtask

  // Scoreboard: consumes exp_q in order; request addresses are checked before the
  // final handshake of the record.
  task automatic drain(input int hold, input bit rnd_ready);
    logic [EXP_W-1:0] exp, act;
    int n;
    bit bad;
    while (exp_q.size() > 0) begin
      n = 0;
      while (bus.out_valid !== 1'b1 && n < 300) begin @(negedge clock); n++; end
      checks++;
      if (bus.out_valid !== 1'b1) begin
        errors++;
        $display("FAIL out_valid_timeout: out_valid=%b required 1", bus.out_valid);
        exp_q.delete();
        exp_addr_q.delete();
        req_log.delete();
        return;
      end
      exp = exp_q.pop_front();
      act = {bus.out_row, bus.out_diag, bus.out_offdiag, bus.out_delta, bus.out_found, bus.out_done};
      checks++;
      if (act !== exp) begin
        errors++;
        $display("FAIL result: got %h required %h", act, exp);
      end
      for (int c = 0; c < hold; c++) begin
        @(negedge clock);
        act = {bus.out_row, bus.out_diag, bus.out_offdiag, bus.out_delta, bus.out_found, bus.out_done};
        checks++;
        if (act !== exp || bus.out_valid !== 1'b1 || bus.mem_req !== 1'b0 || bus.chg_ready !== 1'b0) begin
          errors++;
          $display("FAIL backpressure_hold: got %h v=%b req=%b rdy=%b required %h v=1 req=0 rdy=0",
                   act, bus.out_valid, bus.mem_req, bus.chg_ready, exp);
        end
      end
      if (rnd_ready) repeat ($urandom_range(0, 2)) @(negedge clock);
      if (exp_q.size() == 0) begin
        bad = (req_log.size() != exp_addr_q.size());
        if (!bad) for (int k = 0; k < req_log.size(); k++) if (req_log[k] !== exp_addr_q[k]) bad = 1;
        checks++;
        if (bad) begin
          errors++;
          $display("FAIL mem_requests: got %0d reqs (first %h) required %0d reqs (first %h)",
                   req_log.size(), (req_log.size() > 0) ? req_log[0] : '0,
                   exp_addr_q.size(), (exp_addr_q.size() > 0) ? exp_addr_q[0] : '0);
        end
        req_log.delete();
        exp_addr_q.delete();
      end
`ifdef YFILT_MISS_CNT_EN
      if (exp[2:1] != 2'b11 && exp_miss < 255) exp_miss++;
`endif
      bus.out_ready = 1'b1;
      @(negedge clock);
      bus.out_ready = 1'b0;
`ifdef YFILT_MISS_CNT_EN
      checks++;
      if (miss_cnt !== 8'(exp_miss)) begin
        errors++;
        $display("FAIL miss_cnt: got %0d required %0d", miss_cnt, exp_miss);
      end
`endif
    end
  endtask

  task automatic load_basic_rows();
    mem_words.delete();
    set_slot(6, 0, 16'd3, 48'h0000A1_0000A2);
    set_slot(6, 1, 16'd5, 48'h0000B1_0000B2);
    set_slot(6, 2, 16'd7, 48'h0000C1_0000C2);
    set_slot(10, 0, 16'd3, 48'h0000D1_0000D2);
    set_slot(10, 1, 16'd5, 48'h0000E1_0000E2);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    logic [RST_W-1:0] got, req;
    req = {1'b1, {(RST_W-1){1'b0}}};
    got = {bus.chg_ready, bus.mem_req, bus.mem_addr, bus.out_valid, bus.out_done, bus.out_found,
           bus.out_row, bus.out_diag, bus.out_offdiag, bus.out_delta, dbg_state};
    checks++;
    if (got !== req) begin
      errors++;
      $display("FAIL reset_values: got %h required %h", got, req);
    end
`ifdef YFILT_MISS_CNT_EN
    checks++;
    if (miss_cnt !== 8'd0) begin errors++; $display("FAIL reset_miss_cnt: got %0d required 0", miss_cnt); end
`endif
    reset = 1'b1;
    @(negedge clock);
    checks++;
    if (bus.chg_ready !== 1'b1 || bus.out_valid !== 1'b0 || bus.mem_req !== 1'b0) begin
      errors++;
      $display("FAIL idle_after_reset: rdy=%b v=%b req=%b required 1 0 0",
               bus.chg_ready, bus.out_valid, bus.mem_req);
    end
  endtask

  task automatic test_basic();
    int n;
    mem_lat_max = 1;
    load_basic_rows();
    exp_q.push_back({16'd3, 48'h0000A1_0000A2, 48'h0000B1_0000B2, 48'h000001_000002, 2'b11, 1'b0});
    exp_q.push_back({16'd5, 48'h0000E1_0000E2, 48'h0000D1_0000D2, 48'h000001_000002, 2'b11, 1'b1});
    exp_addr_q.push_back(16'd6);
    exp_addr_q.push_back(16'd10);
    bus.chg_valid = 1'b1;
    bus.chg_row = 16'd3;
    bus.chg_col = 16'd5;
    bus.chg_delta = 48'h000001_000002;
    n = 0;
    do begin
      @(negedge clock);
      bus.chg_valid = 1'b0;
      n++;
    end while (bus.out_valid !== 1'b1 && n < 50);
    checks++;
    if (n != 4) begin
      errors++;
      $display("FAIL first_latency: got %0d cycles required 4", n);
    end
    drain(0, 0);
  endtask

  task automatic test_multi_word();
    load_basic_rows();
    set_slot(6, 0, 16'd1, 48'h111111_111111);
    set_slot(6, 1, 16'd2, 48'h222222_222222);
    set_slot(6, 2, 16'd4, 48'h444444_444444);
    set_slot(6, 3, 16'd6, 48'h666666_666666);
    set_slot(7, 0, 16'd3, 48'h0000A1_0000A2);
    set_slot(7, 1, 16'd5, 48'h0000B1_0000B2);
    exp_q.push_back({16'd3, 48'h0000A1_0000A2, 48'h0000B1_0000B2, 48'h123456_789ABC, 2'b11, 1'b0});
    exp_q.push_back({16'd5, 48'h0000E1_0000E2, 48'h0000D1_0000D2, 48'h123456_789ABC, 2'b11, 1'b1});
    exp_addr_q.push_back(16'd6);
    exp_addr_q.push_back(16'd7);
    exp_addr_q.push_back(16'd10);
    send_record(16'd3, 16'd5, 48'h123456_789ABC);
    drain(0, 0);
  endtask

  task automatic test_missing_offdiag();
    load_basic_rows();
    mem_words.delete(6);
    set_slot(6, 0, 16'd3, 48'h0000A1_0000A2);
    exp_q.push_back({16'd3, 48'h0000A1_0000A2, 48'h0, 48'h00000F_00000E, 2'b10, 1'b0});
    exp_q.push_back({16'd5, 48'h0000E1_0000E2, 48'h0000D1_0000D2, 48'h00000F_00000E, 2'b11, 1'b1});
    exp_addr_q.push_back(16'd6);
    exp_addr_q.push_back(16'd10);
    send_record(16'd3, 16'd5, 48'h00000F_00000E);
    drain(0, 0);
  endtask

  task automatic test_backpressure();
    load_basic_rows();
    mem_lat_max = 3;
    expect_record(16'd3, 16'd5, 48'hBEEF00_00CAFE);
    send_record(16'd3, 16'd5, 48'hBEEF00_00CAFE);
    drain(10, 0);
    mem_lat_max = 1;
  endtask

  task automatic test_diagonal();
    int n;
    mem_words.delete();
    set_slot(8, 0, 16'd2, 48'h020202_020202);
    set_slot(8, 1, 16'd4, 48'h040404_040404);
    exp_q.push_back({16'd4, 48'h040404_040404, 48'h040404_040404, 48'h000044_000044, 2'b11, 1'b1});
    exp_addr_q.push_back(16'd8);
    send_record(16'd4, 16'd4, 48'h000044_000044);
    drain(0, 0);
    n = 0;
    repeat (8) begin
      @(negedge clock);
      if (bus.out_valid !== 1'b0 || bus.mem_req !== 1'b0 || bus.chg_ready !== 1'b1) n++;
    end
    checks++;
    if (n != 0 || req_log.size() != 0) begin
      errors++;
      $display("FAIL diag_single_pass: got %0d busy cycles, %0d reqs required 0, 0", n, req_log.size());
    end
    req_log.delete();
  endtask

  task automatic test_reset_mid_op();
    logic [VAL_W-1:0] dv, ov;
    logic [1:0] f;
    int nw, n;
    logic [RST_W-1:0] got, req;
    load_basic_rows();
    mem_lat_max = 1;
    model_row(16'd3, 16'd5, dv, ov, f, nw);
    exp_q.push_back({16'd3, dv, ov, 48'h0000AA_0000BB, f, 1'b0});
    exp_addr_q.push_back(16'd6);
    send_record(16'd3, 16'd5, 48'h0000AA_0000BB);
    drain(0, 0);
    n = 0;
    while (bus.mem_req !== 1'b1 && n < 20) begin @(negedge clock); n++; end
    @(negedge clock);
    checks++;
    if (dbg_state !== 3'd2) begin
      errors++;
      $display("FAIL pass1_wait_state: got %0d required 2", dbg_state);
    end
    reset = 1'b0;
    #1;
    req = {1'b1, {(RST_W-1){1'b0}}};
    got = {bus.chg_ready, bus.mem_req, bus.mem_addr, bus.out_valid, bus.out_done, bus.out_found,
           bus.out_row, bus.out_diag, bus.out_offdiag, bus.out_delta, dbg_state};
    checks++;
    if (got !== req) begin
      errors++;
      $display("FAIL mid_reset_values: got %h required %h", got, req);
    end
`ifdef YFILT_MISS_CNT_EN
    exp_miss = 0;
`endif
    repeat (3) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    req_log.delete();
    checks++;
    if (bus.out_valid !== 1'b0 || bus.chg_ready !== 1'b1) begin
      errors++;
      $display("FAIL no_emit_after_reset: v=%b rdy=%b required 0 1", bus.out_valid, bus.chg_ready);
    end
    expect_record(16'd5, 16'd3, 48'h000077_000088);
    send_record(16'd5, 16'd3, 48'h000077_000088);
    drain(0, 0);
  endtask

  task automatic test_random();
    logic [IDX_W-1:0] i, j;
    logic [VAL_W-1:0] d;
    mem_words.delete();
    mem_lat_max = 3;
    for (int r = 0; r < 8; r++)
      for (int w = 0; w < WPR; w++)
        for (int k = 0; k < SLOTS; k++)
          set_slot(r * WPR + w, k,
                   ($urandom_range(0, 5) == 0) ? EMPTY : IDX_W'($urandom_range(0, 9)),
                   VAL_W'({$urandom(), $urandom()}));
    for (int t = 0; t < 24; t++) begin
      i = IDX_W'($urandom_range(0, 7));
      j = ($urandom_range(0, 4) == 0) ? i : IDX_W'($urandom_range(0, 7));
      d = VAL_W'({$urandom(), $urandom()});
      expect_record(i, j, d);
      send_record(i, j, d);
      drain(0, 1);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.chg_valid = 1'b0;
    bus.chg_row = '0;
    bus.chg_col = '0;
    bus.chg_delta = '0;
    bus.out_ready = 1'b0;
    repeat (3) @(negedge clock);
    test_reset();
    test_basic();
    test_multi_word();
    test_missing_offdiag();
    test_backpressure();
    test_diagonal();
    test_reset_mid_op();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
